// File: rtl/spi_slave_rx.sv
// SPI slave receiver: synchronizes the master's SPI signals into the clk domain,
// assembles MSB-first frames and buffers complete words in a first-word fall-through FIFO.
module spi_slave_rx #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          spi_ssal,
    input  logic                          spi_mclk,
    input  logic                          spi_dat,
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic [DATA_W-1:0]             dat_out,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic [4:0]                    bit_count,
    output logic                          busy,
    output logic                          frame_err,
    output logic                          ovf
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;
    localparam logic [AW-1:0]    PTR_ONE  = 1;
    localparam logic [LVL_W-1:0] LVL_ONE  = 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [4:0]       LAST_BIT = 5'(DATA_W - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t            state;
    logic              ssal_meta, ssal_sync;
    logic              mclk_meta, mclk_sync, mclk_prev;
    logic              dat_meta, dat_sync;
    logic [1:0]        settle;
    logic              armed;
    logic [DATA_W-1:0] shreg;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;

    logic              mclk_rise, last_bit, push, abort, pop, wr_ok, drop;
    logic [DATA_W-1:0] word;

    // settle[1] marks the point where ssal_sync carries a real sample rather than its reset value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ssal_meta <= 1'b1;
            ssal_sync <= 1'b1;
            mclk_meta <= 1'b0;
            mclk_sync <= 1'b0;
            mclk_prev <= 1'b0;
            dat_meta  <= 1'b0;
            dat_sync  <= 1'b0;
            settle    <= 2'b00;
        end else begin
            ssal_meta <= spi_ssal;
            ssal_sync <= ssal_meta;
            mclk_meta <= spi_mclk;
            mclk_sync <= mclk_meta;
            mclk_prev <= mclk_sync;
            dat_meta  <= spi_dat;
            dat_sync  <= dat_meta;
            settle    <= {settle[0], 1'b1};
        end
    end

    assign mclk_rise = mclk_sync & ~mclk_prev;
    assign last_bit  = (bit_count == LAST_BIT);
    assign word      = {shreg[DATA_W-2:0], dat_sync};
    assign push      = (state == SHIFT) & ~ssal_sync & mclk_rise & last_bit;
    assign abort     = (state == SHIFT) & ssal_sync & (bit_count != 5'd0);
    assign busy      = (state == SHIFT);

    // armed is only set by seeing ssal high after reset, so a frame cut by reset is not resumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_count <= 5'd0;
            armed     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (settle[1] && ssal_sync)
                        armed <= 1'b1;
                    if (armed && !ssal_sync)
                        state <= SHIFT;
                end
                SHIFT: begin
                    if (ssal_sync) begin
                        state     <= IDLE;
                        shreg     <= '0;
                        bit_count <= 5'd0;
                    end else if (mclk_rise) begin
                        shreg     <= word;
                        bit_count <= last_bit ? 5'd0 : bit_count + 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign empty   = (level == '0);
    assign full    = (level == LVL_FULL);
    assign pop     = rd_en & ~empty;
    assign wr_ok   = push & (~full | pop);
    assign drop    = push & full & ~pop;
    assign dat_out = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_ok, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // when full, a simultaneous pop frees the slot wr_ptr points at, so the write is safe
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (abort)
                frame_err <= 1'b1;
            else if (err_clr)
                frame_err <= 1'b0;
            if (drop)
                ovf <= 1'b1;
            else if (err_clr)
                ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Randomized bench for spi_slave_rx: a frame-level model predicts FIFO contents and
// sticky flags; a monitor pops the expected queue on every rd_en and compares.
module tb_spi_slave_rx;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          spi_ssal = 1'b1;
    logic          spi_mclk = 1'b0;
    logic          spi_dat = 1'b0;
    logic          rd_en = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] dat_out;
    logic          empty, full, busy, frame_err, ovf;
    logic [2:0]    level;
    logic [4:0]    bit_count;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q[$];
    logic          model_ferr = 1'b0;
    logic          model_ovf = 1'b0;
    int            model_bits = 0;
    bit            model_armed = 1'b1;

    spi_slave_rx #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .spi_ssal(spi_ssal), .spi_mclk(spi_mclk),
        .spi_dat(spi_dat), .rd_en(rd_en), .err_clr(err_clr), .dat_out(dat_out),
        .empty(empty), .full(full), .level(level), .bit_count(bit_count),
        .busy(busy), .frame_err(frame_err), .ovf(ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rd_en) begin
            if (exp_q.size() == 0)
                check("pop_while_empty", 32'(empty), 32'd1);
            else
                check("pop_data", {15'd0, empty, dat_out}, {16'd0, exp_q.pop_front()});
        end
    end

    task automatic model_push(input logic [DW-1:0] w);
        if (exp_q.size() < DEPTH) exp_q.push_back(w);
        else model_ovf = 1'b1;
    endtask

    task automatic send_bit(input logic b, input bit pop_at_edge);
        spi_mclk = 1'b0;
        spi_dat  = b;
        repeat (4) @(posedge clk);
        #1 spi_mclk = 1'b1;
        if (pop_at_edge) begin
            // rising edge is detected two clk edges later; the push lands on the third
            repeat (2) @(posedge clk);
            #1 rd_en = 1'b1;
            @(posedge clk);
            #1 rd_en = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            repeat (4) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [DW-1:0] w, input int nbits, input bit pop_last);
        for (int i = 0; i < nbits; i++) begin
            send_bit(w[DW-1-i], pop_last && (i == DW - 1));
            if (model_armed) begin
                model_bits++;
                if (model_bits == DW) begin
                    model_push(w);
                    model_bits = 0;
                end
            end
        end
    endtask

    task automatic sel_low();
        spi_ssal = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic sel_high();
        spi_mclk = 1'b0;
        repeat (3) @(posedge clk);
        #1 spi_ssal = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        if (model_bits != 0) model_ferr = 1'b1;
        model_bits  = 0;
        model_armed = 1'b1;
    endtask

    task automatic pop_one();
        @(posedge clk);
        #1 rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
    endtask

    task automatic clear_errs();
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        model_ferr = 1'b0;
        model_ovf  = 1'b0;
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        check({tag, "_level"}, 32'(level), 32'(exp_q.size()));
        check({tag, "_empty"}, 32'(empty), 32'(exp_q.size() == 0));
        check({tag, "_full"}, 32'(full), 32'(exp_q.size() == DEPTH));
        check({tag, "_frame_err"}, 32'(frame_err), 32'(model_ferr));
        check({tag, "_ovf"}, 32'(ovf), 32'(model_ovf));
        if (exp_q.size() > 0)
            check({tag, "_head"}, 32'(dat_out), 32'(exp_q[0]));
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_dat_out"}, 32'(dat_out), 32'd0);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_full"}, 32'(full), 32'd0);
        check({tag, "_level"}, 32'(level), 32'd0);
        check({tag, "_bit_count"}, 32'(bit_count), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check({tag, "_ovf"}, 32'(ovf), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        check_reset_outputs("rst_hold");
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_reset_outputs("after_rst");

        // single frame
        sel_low();
        send_word(16'hA563, DW, 1'b0);
        sel_high();
        check_state("single");
        pop_one();
        check_state("single_drained");

        // back-to-back frames under one select
        sel_low();
        send_word(16'hFFFF, DW, 1'b0);
        send_word(16'h89DD, DW, 1'b0);
        sel_high();
        check_state("b2b");
        pop_one();
        pop_one();
        pop_one();
        check_state("b2b_drained");

        // aborted frame
        sel_low();
        send_word(16'hB000, 5, 1'b0);
        @(negedge clk);
        check("abort_bit_count", 32'(bit_count), 32'd5);
        check("abort_busy", 32'(busy), 32'd1);
        sel_high();
        check_state("abort");
        check("abort_bit_count_clr", 32'(bit_count), 32'd0);
        clear_errs();
        check_state("abort_cleared");

        // overflow
        for (int i = 1; i <= 5; i++) begin
            sel_low();
            send_word(16'(i), DW, 1'b0);
            sel_high();
        end
        check_state("overflow");
        clear_errs();
        check_state("overflow_cleared");

        // push with simultaneous pop while full
        sel_low();
        send_word(16'h246E, DW, 1'b1);
        sel_high();
        check_state("push_pop_full");
        for (int i = 0; i < DEPTH; i++) pop_one();
        check_state("push_pop_drained");

        // randomized traffic
        for (int it = 0; it < 25; it++) begin
            int nframes;
            nframes = $urandom_range(1, 3);
            sel_low();
            for (int f = 0; f < nframes; f++)
                send_word(16'($urandom), DW, 1'b0);
            if ($urandom_range(0, 3) == 0)
                send_word(16'($urandom), $urandom_range(1, DW - 1), 1'b0);
            sel_high();
            repeat ($urandom_range(0, 4)) pop_one();
            check_state("rand");
            if ($urandom_range(0, 2) == 0) clear_errs();
        end
        while (exp_q.size() > 0) pop_one();
        clear_errs();
        check_state("rand_drained");

        // reset mid-frame, then confirm reception only resumes after a fresh select
        sel_low();
        send_word(16'h5A5A, 8, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        model_ferr  = 1'b0;
        model_ovf   = 1'b0;
        model_bits  = 0;
        model_armed = 1'b0;
        repeat (2) @(posedge clk);
        check_reset_outputs("mid_rst");
        #1 rst = 1'b0;
        send_word(16'hF000, 4, 1'b0);
        @(negedge clk);
        check("post_rst_bit_count", 32'(bit_count), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        sel_high();
        check_state("post_rst_idle");
        sel_low();
        send_word(16'hA563, DW, 1'b0);
        sel_high();
        check_state("post_rst_frame");
        pop_one();
        check_state("post_rst_drained");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
